// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and a
// small elaboration-time helper.
package reset_seq_pkg;

   typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_SW  = 2'b01;
   localparam logic [1:0] CAUSE_WDT = 2'b10;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Deassertion synchroniser: clears asynchronously with the pad reset and
// shifts in a constant 1, so release only ever happens on a clock edge.
module reset_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_sync
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_chain <= '0;
      else          r_chain <= {r_chain[STAGES-2:0], 1'b1};
   end

   assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset generator: async assert, synchronised and staggered release,
// software/watchdog re-issue with cause recording. Every output is a flop.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned NUM_DOMAINS = 4,
   parameter int unsigned STAGGER     = 4
) (
   input  logic                   CLK,
   input  logic                   R,
   input  logic                   SW_RST_REQ,
   input  logic                   WDT_EXPIRE,
   output logic [NUM_DOMAINS-1:0] RST_N,
   output logic                   RST_DONE,
   output logic [1:0]             RST_CAUSE
);

   localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, STAGGER * (NUM_DOMAINS - 1));
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t                 r_state, w_state;
   logic [CNT_W-1:0]       r_cnt, w_cnt, w_cnt_inc;
   logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n, w_stagger_hit;
   logic                   r_done, w_done;
   logic [1:0]             r_cause, w_cause;
   logic                   w_sync;

   reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (CLK),
      .i_rst_n (R),
      .o_sync  (w_sync)
   );

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // RELEASE counts edges since domain 0 came out; domain i follows STAGGER*i later.
   always_comb begin
      w_stagger_hit = '0;
      for (int unsigned i = 1; i < NUM_DOMAINS; i++)
         w_stagger_hit[i] = (w_cnt_inc == CNT_W'(STAGGER * i));
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_rst_n = r_rst_n;
      w_done  = r_done;
      w_cause = r_cause;
      case (r_state)
         SYNC: begin
            if (w_sync) begin
               w_state = HOLD;
               w_cnt   = '0;
            end
         end
         HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state    = RELEASE;
               w_cnt      = '0;
               w_rst_n[0] = 1'b1;
            end else begin
               w_cnt = w_cnt_inc;
            end
         end
         RELEASE: begin
            if (&r_rst_n) begin
               w_state = RUN;
               w_cnt   = '0;
               w_done  = 1'b1;
            end else begin
               w_cnt   = w_cnt_inc;
               w_rst_n = r_rst_n | w_stagger_hit;
            end
         end
         RUN: begin
            // Watchdog takes priority when both requests land on the same edge.
            if (WDT_EXPIRE || SW_RST_REQ) begin
               w_state = HOLD;
               w_cnt   = '0;
               w_rst_n = '0;
               w_done  = 1'b0;
               w_cause = WDT_EXPIRE ? CAUSE_WDT : CAUSE_SW;
            end
         end
         default: w_state = SYNC;
      endcase
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         r_state <= SYNC;
         r_cnt   <= '0;
         r_rst_n <= '0;
         r_done  <= 1'b0;
         r_cause <= CAUSE_POR;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_rst_n <= w_rst_n;
         r_done  <= w_done;
         r_cause <= w_cause;
      end
   end

   assign RST_N     = r_rst_n;
   assign RST_DONE  = r_done;
   assign RST_CAUSE = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: POR timing table, request/abort sequences and a
// randomized run against an edge-count reference model.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   localparam int SS = 2;
   localparam int HC = 16;
   localparam int ND = 4;
   localparam int ST = 4;

   logic          CLK = 1'b0;
   logic          R   = 1'b1;
   logic          sw  = 1'b0;
   logic          wdt = 1'b0;
   logic          sw1 = 1'b0;
   logic          wdt1 = 1'b0;
   logic [ND-1:0] rst_n;
   logic          done;
   logic [1:0]    cause;
   logic [0:0]    rst_n1;
   logic          done1;
   logic [1:0]    cause1;

   always #5 CLK = ~CLK;

   reset_sequencer #(.SYNC_STAGES(SS), .HOLD_CYCLES(HC), .NUM_DOMAINS(ND), .STAGGER(ST)) u_dut (
      .CLK(CLK), .R(R), .SW_RST_REQ(sw), .WDT_EXPIRE(wdt),
      .RST_N(rst_n), .RST_DONE(done), .RST_CAUSE(cause)
   );

   reset_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGGER(1)) u_dut1 (
      .CLK(CLK), .R(R), .SW_RST_REQ(sw1), .WDT_EXPIRE(wdt1),
      .RST_N(rst_n1), .RST_DONE(done1), .RST_CAUSE(cause1)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: edge index since R rose, and the edge at which the hold phase began.
   int            m_k;
   int            m_h;
   logic [ND-1:0] m_rst;
   logic          m_done;
   logic [1:0]    m_cause;

   function automatic void model_eval();
      for (int i = 0; i < ND; i++) m_rst[i] = (m_k >= m_h + HC + ST * i);
      m_done = (m_k >= m_h + HC + ST * (ND - 1) + 1);
   endfunction

   function automatic void model_por();
      m_k     = 0;
      m_h     = SS + 1;
      m_cause = CAUSE_POR;
      model_eval();
   endfunction

   function automatic void model_edge(input logic s, input logic w);
      if (R !== 1'b1) return;
      m_k++;
      if (m_done && (s || w)) begin
         m_h     = m_k;
         m_cause = w ? CAUSE_WDT : CAUSE_SW;
      end
      model_eval();
   endfunction

   task automatic step();
      @(posedge CLK);
      model_edge(sw, wdt);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " rst"},   32'(rst_n), 32'(m_rst));
      chk({tag, " done"},  32'(done),  32'(m_done));
      chk({tag, " cause"}, 32'(cause), 32'(m_cause));
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      chk({tag, " reach RUN"}, 32'(done), 32'd1);
   endtask

   typedef struct {
      int            k;
      logic [ND-1:0] rst;
      logic          dn;
      logic [1:0]    cs;
      logic          r1;
      logic          d1;
   } por_vec_t;

   typedef struct {
      logic       s;
      logic       w;
      logic [1:0] cs;
   } req_vec_t;

   por_vec_t pv [13];
   req_vec_t rv [3];

   task automatic run_por_table(input string tag);
      for (int j = 0; j < 13; j++) begin
         while (m_k < pv[j].k) step();
         chk($sformatf("%s k=%0d rst", tag, pv[j].k),   32'(rst_n),  32'(pv[j].rst));
         chk($sformatf("%s k=%0d done", tag, pv[j].k),  32'(done),   32'(pv[j].dn));
         chk($sformatf("%s k=%0d cause", tag, pv[j].k), 32'(cause),  32'(pv[j].cs));
         chk($sformatf("%s k=%0d d1rst", tag, pv[j].k), 32'(rst_n1), 32'(pv[j].r1));
         chk($sformatf("%s k=%0d d1done", tag, pv[j].k), 32'(done1), 32'(pv[j].d1));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int e;
      int last;
      int pulses;

      pv[0]  = '{1,  4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
      pv[1]  = '{3,  4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
      pv[2]  = '{4,  4'b0000, 1'b0, 2'b00, 1'b1, 1'b0};
      pv[3]  = '{5,  4'b0000, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[4]  = '{18, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[5]  = '{19, 4'b0001, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[6]  = '{22, 4'b0001, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[7]  = '{23, 4'b0011, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[8]  = '{26, 4'b0011, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[9]  = '{27, 4'b0111, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[10] = '{30, 4'b0111, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[11] = '{31, 4'b1111, 1'b0, 2'b00, 1'b1, 1'b1};
      pv[12] = '{32, 4'b1111, 1'b1, 2'b00, 1'b1, 1'b1};

      rv[0] = '{1'b1, 1'b0, CAUSE_SW};
      rv[1] = '{1'b1, 1'b1, CAUSE_WDT};
      rv[2] = '{1'b0, 1'b1, CAUSE_WDT};

      // Power-on reset
      #2 R = 1'b0;
      model_por();
      repeat (5) step();
      chk("reset rst",    32'(rst_n),  32'd0);
      chk("reset done",   32'(done),   32'd0);
      chk("reset cause",  32'(cause),  32'd0);
      chk("reset d1rst",  32'(rst_n1), 32'd0);
      chk("reset d1done", 32'(done1),  32'd0);
      R = 1'b1;
      run_por_table("por");

      // Single-edge requests from RUN
      for (int j = 0; j < 3; j++) begin
         wait_done("req");
         sw  = rv[j].s;
         wdt = rv[j].w;
         step();
         e   = m_k;
         sw  = 1'b0;
         wdt = 1'b0;
         chk($sformatf("req%0d rst@e", j),   32'(rst_n), 32'd0);
         chk($sformatf("req%0d done@e", j),  32'(done),  32'd0);
         chk($sformatf("req%0d cause@e", j), 32'(cause), 32'(rv[j].cs));
         while (m_k < e + 15) step();
         chk($sformatf("req%0d rst@e+15", j), 32'(rst_n), 32'd0);
         step();
         chk($sformatf("req%0d rst@e+16", j), 32'(rst_n), 32'b0001);
         while (m_k < e + 28) step();
         chk($sformatf("req%0d done@e+28", j), 32'(done), 32'd0);
         step();
         chk($sformatf("req%0d done@e+29", j),  32'(done),  32'd1);
         chk($sformatf("req%0d rst@e+29", j),   32'(rst_n), 32'b1111);
         chk($sformatf("req%0d cause@e+29", j), 32'(cause), 32'(rv[j].cs));
      end

      // Request held high: RST_DONE pulses once every 30 cycles
      wait_done("held");
      sw     = 1'b1;
      last   = -1;
      pulses = 0;
      for (int c = 0; c < 95; c++) begin
         step();
         if (done) begin
            if (last >= 0) chk("held gap", 32'(m_k - last), 32'd30);
            last = m_k;
            pulses++;
         end
      end
      sw = 1'b0;
      chk("held pulses", 32'(pulses), 32'd3);

      // A request pulse during HOLD is dropped
      wait_done("noq");
      sw = 1'b1;
      step();
      e  = m_k;
      sw = 1'b0;
      repeat (4) step();
      sw = 1'b1;
      step();
      sw = 1'b0;
      while (m_k < e + 29) step();
      chk("noq done@e+29", 32'(done), 32'd1);
      repeat (4) step();
      chk("noq still RUN", 32'(done), 32'd1);

      // Pad reset mid-RELEASE, between clock edges
      wait_done("mid");
      sw = 1'b1;
      step();
      e  = m_k;
      sw = 1'b0;
      while (m_k < e + 20) step();
      chk("mid rst before", 32'(rst_n), 32'b0011);
      chk("mid cause before", 32'(cause), 32'(CAUSE_SW));
      #3 R = 1'b0;
      model_por();
      #1;
      chk("mid async rst",   32'(rst_n), 32'd0);
      chk("mid async done",  32'(done),  32'd0);
      chk("mid async cause", 32'(cause), 32'd0);
      repeat (2) step();
      R = 1'b1;
      run_por_table("repor");

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            R = 1'b0;
            model_por();
            #1;
            chk_model("rnd async");
            repeat ($urandom_range(1, 3)) step();
            R = 1'b1;
         end
         sw  = ($urandom_range(0, 7) == 0);
         wdt = ($urandom_range(0, 15) == 0);
         step();
         chk_model("rnd");
      end
      sw  = 1'b0;
      wdt = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
